// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch redirect flushes and memory-wait freeze.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             pc_redirect,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             if_valid,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [1:0]       state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events
`endif
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        load_use;

    assign load_use = ex_valid & ex_is_load & (ex_rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_write    = 1'b1;
        pc_redirect = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        if_valid    = 1'b1;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        // Busy cycles are counted in every state; any ready cycle clears the count.
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = '0;
        end
        timeout_d = timeout_q | (mem_busy & (wait_cnt_d == 16'(MEM_TIMEOUT)));

        if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            if (state_q == StRun) begin
                state_d = StMemWait;
            end
        end else if (state_q == StFlush) begin
            ifid_flush = 1'b1;
            if_valid   = 1'b0;
            if (flush_cnt_q <= 4'd1) begin
                state_d     = StRun;
                flush_cnt_d = '0;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end else begin
            // RUN, and the release cycle of MEM_WAIT, share the same rules.
            state_d = StRun;
            if (ex_valid && branch_taken) begin
                pc_redirect = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                if_valid    = 1'b0;
                if (FLUSH_CYCLES > 1) begin
                    state_d     = StFlush;
                    flush_cnt_d = 4'(FLUSH_CYCLES - 1);
                end
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign state_o     = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (pc_redirect) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance a (FLUSH_CYCLES=3, MEM_TIMEOUT=255) and
// instance b (FLUSH_CYCLES=1, MEM_TIMEOUT=3) share one set of inputs.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W = 5;

    // Control vector order: {pc_write, pc_redirect, ifid_stall, ifid_flush, if_valid,
    //                        idex_stall, idex_flush}
    localparam logic [6:0] C_IDLE   = 7'b1000100;
    localparam logic [6:0] C_LU     = 7'b0010101;
    localparam logic [6:0] C_REDIR  = 7'b1101001;
    localparam logic [6:0] C_FLUSH  = 7'b1001000;
    localparam logic [6:0] C_FREEZE = 7'b0010110;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2, ex_valid, ex_is_load, branch_taken, mem_busy;

    logic a_pcw, a_red, a_ifs, a_iff, a_ifv, a_ids, a_idf, a_to;
    logic b_pcw, b_red, b_ifs, b_iff, b_ifv, b_ids, b_idf, b_to;
    logic [1:0] a_st, b_st;
    logic [6:0] a_ctrl, b_ctrl;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] a_stall, a_flev, b_stall, b_flev;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign a_ctrl = {a_pcw, a_red, a_ifs, a_iff, a_ifv, a_ids, a_idf};
    assign b_ctrl = {b_pcw, b_red, b_ifs, b_iff, b_ifv, b_ids, b_idf};

    pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(3), .MEM_TIMEOUT(255)) u_dut_a (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(a_pcw), .pc_redirect(a_red), .ifid_stall(a_ifs),
        .ifid_flush(a_iff), .if_valid(a_ifv), .idex_stall(a_ids), .idex_flush(a_idf),
        .mem_timeout(a_to), .state_o(a_st)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cycles(a_stall), .flush_events(a_flev)
`endif
    );

    pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(1), .MEM_TIMEOUT(3)) u_dut_b (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .pc_write(b_pcw), .pc_redirect(b_red), .ifid_stall(b_ifs),
        .ifid_flush(b_iff), .if_valid(b_ifv), .idex_stall(b_ids), .idex_flush(b_idf),
        .mem_timeout(b_to), .state_o(b_st)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        , .stall_cycles(b_stall), .flush_events(b_flev)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        repeat (2) cyc();
        check_eq("rst_a_ctrl", 32'(a_ctrl), 32'(C_IDLE));
        check_eq("rst_a_state", 32'(a_st), 32'd0);
        check_eq("rst_b_timeout", 32'(b_to), 32'd0);
        reset = 1'b1;

        // Load-use hazards
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_uses_rs2 = 1'b1; id_rs2 = 5'd5;
        @(negedge clk);
        check_eq("lu_rs2_a", 32'(a_ctrl), 32'(C_LU));
        check_eq("lu_rs2_b", 32'(b_ctrl), 32'(C_LU));
        check_eq("lu_rs2_state", 32'(a_st), 32'd0);
        cyc(); idle();
        @(negedge clk);
        check_eq("lu_once", 32'(a_ctrl), 32'(C_IDLE));
        cyc();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        @(negedge clk);
        check_eq("lu_rd0", 32'(a_ctrl), 32'(C_IDLE));
        cyc();
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd3;
        @(negedge clk);
        check_eq("lu_unused", 32'(a_ctrl), 32'(C_IDLE));
        cyc();
        id_uses_rs1 = 1'b1;
        @(negedge clk);
        check_eq("lu_rs1", 32'(a_ctrl), 32'(C_LU));
        cyc();
        ex_is_load = 1'b0;
        @(negedge clk);
        check_eq("lu_noload", 32'(a_ctrl), 32'(C_IDLE));
        cyc(); idle();

        // Branch redirect; load-use ignored while flushing
        ex_valid = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        check_eq("br_c0_a", 32'(a_ctrl), 32'(C_REDIR));
        check_eq("br_c0_b", 32'(b_ctrl), 32'(C_REDIR));
        cyc(); idle();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4; id_uses_rs1 = 1'b1; id_rs1 = 5'd4;
        @(negedge clk);
        check_eq("br_c1_a", 32'(a_ctrl), 32'(C_FLUSH));
        check_eq("br_c1_state", 32'(a_st), 32'd1);
        check_eq("br_c1_b_lu", 32'(b_ctrl), 32'(C_LU));
        check_eq("br_c1_b_state", 32'(b_st), 32'd0);
        cyc(); idle();
        @(negedge clk);
        check_eq("br_c2_a", 32'(a_ctrl), 32'(C_FLUSH));
        check_eq("br_c2_state", 32'(a_st), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("br_c3_state", 32'(a_st), 32'd0);
        check_eq("br_c3_a", 32'(a_ctrl), 32'(C_IDLE));
        cyc();
        branch_taken = 1'b1;
        @(negedge clk);
        check_eq("br_novalid", 32'(a_ctrl), 32'(C_IDLE));
        cyc(); idle();

        // Branch and load-use together: redirect wins
        ex_valid = 1'b1; branch_taken = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd4;
        id_uses_rs1 = 1'b1; id_rs1 = 5'd4;
        @(negedge clk);
        check_eq("br_lu_a", 32'(a_ctrl), 32'(C_REDIR));
        cyc(); idle();
        repeat (2) cyc();
        @(negedge clk);
        check_eq("br_lu_done", 32'(a_st), 32'd0);
        cyc();

        // Four busy cycles, branch honoured on the release cycle
        mem_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq($sformatf("mw%0d_a", k), 32'(a_ctrl), 32'(C_FREEZE));
            check_eq($sformatf("mw%0d_a_to", k), 32'(a_to), 32'd0);
            if (k > 1) check_eq($sformatf("mw%0d_state", k), 32'(a_st), 32'd2);
            if (k == 2) check_eq("mw2_b_to", 32'(b_to), 32'd0);
            if (k == 4) check_eq("mw4_b_to", 32'(b_to), 32'd1);
            cyc();
        end
        mem_busy = 1'b0; ex_valid = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        check_eq("mw_rel_br", 32'(a_ctrl), 32'(C_REDIR));
        check_eq("mw_rel_state", 32'(a_st), 32'd2);
        cyc(); idle();
        @(negedge clk);
        check_eq("mw_rel_flush", 32'(a_st), 32'd1);
        check_eq("b_sticky", 32'(b_to), 32'd1);

        // Asynchronous reset mid-FLUSH
        #1 reset = 1'b0;
        #1;
        check_eq("arst_a_state", 32'(a_st), 32'd0);
        check_eq("arst_a_ctrl", 32'(a_ctrl), 32'(C_IDLE));
        check_eq("arst_b_to", 32'(b_to), 32'd0);
        cyc();
        reset = 1'b1;

        // Timeout on b after three busy cycles, sticky after release
        mem_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("to%0d_b", k), 32'(b_ctrl), 32'(C_FREEZE));
            if (k == 2) check_eq("to2_b_to", 32'(b_to), 32'd0);
            if (k >= 4) check_eq($sformatf("to%0d_b_to", k), 32'(b_to), 32'd1);
            cyc();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check_eq("to_rel_b", 32'(b_ctrl), 32'(C_IDLE));
        check_eq("to_rel_state", 32'(b_st), 32'd2);
        check_eq("to_rel_b_to", 32'(b_to), 32'd1);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        check_eq("perf_b_stall", b_stall, 32'd5);
        check_eq("perf_b_flev", b_flev, 32'd0);
`endif
        cyc();
        @(negedge clk);
        check_eq("to_after_state", 32'(b_st), 32'd0);
        check_eq("to_after_b_to", 32'(b_to), 32'd1);
        cyc();

        // Memory busy during FLUSH holds the flush count
        ex_valid = 1'b1; branch_taken = 1'b1;
        @(negedge clk);
        check_eq("fb_br", 32'(a_ctrl), 32'(C_REDIR));
        cyc(); idle();
        mem_busy = 1'b1;
        @(negedge clk);
        check_eq("fb_freeze", 32'(a_ctrl), 32'(C_FREEZE));
        check_eq("fb_state1", 32'(a_st), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("fb_state2", 32'(a_st), 32'd1);
        cyc();
        mem_busy = 1'b0;
        @(negedge clk);
        check_eq("fb_rel_ctrl", 32'(a_ctrl), 32'(C_FLUSH));
        check_eq("fb_rel_state", 32'(a_st), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("fb_last_state", 32'(a_st), 32'd1);
        cyc();
        @(negedge clk);
        check_eq("fb_done_state", 32'(a_st), 32'd0);
        check_eq("fb_a_to", 32'(a_to), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the stall/flush/valid controls of the IF/ID and ID/EX pipeline registers and the PC write enable. It resolves load-use hazards, taken-branch redirects and data-memory wait states. It also tracks wait length with a timeout counter and sits beside the fetch stage and the ifid register.

Parameters:
REG_W, 5, register-index width
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a redirect (1..15)
MEM_TIMEOUT, 255, max consecutive mem_busy cycles before mem_timeout (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1  in  REG_W  ID-stage source 1 index
id_rs2  in  REG_W  ID-stage source 2 index
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX stage holds a valid instruction
ex_is_load  in  1  EX instruction is a load
ex_rd  in  REG_W  EX destination index
branch_taken  in  1  EX resolved a taken branch/jump (valid only with ex_valid)
mem_busy  in  1  data memory not ready; whole pipe must freeze
pc_write  out  1  PC register enable
pc_redirect  out  1  select branch target for next PC
ifid_stall  out  1  IF/ID hold
ifid_flush  out  1  IF/ID load bubble (valid_out=0)
if_valid  out  1  valid bit presented to IF/ID
idex_stall  out  1  ID/EX hold
idex_flush  out  1  ID/EX load bubble
mem_timeout  out  1  sticky error flag
state_o  out  2  current FSM state (RUN=0, FLUSH=1, MEM_WAIT=2)

Behaviour:
- Reset (reset=0, async): state=RUN, flush_cnt=0, wait_cnt=0, mem_timeout=0.
- Control outputs are combinational from state and current inputs. The state and counters are registered.
- Defaults: pc_write=1, if_valid=1, all other control outputs 0.
- load_use = ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority in every state: mem_busy > branch_taken > load_use.
- RUN:
  - If mem_busy: pc_write=0, ifid_stall=1, idex_stall=1. Next state MEM_WAIT, wait_cnt=1.
  - Else if ex_valid & branch_taken: pc_redirect=1, ifid_flush=1, idex_flush=1, if_valid=0. Next state FLUSH if FLUSH_CYCLES>1 (flush_cnt=FLUSH_CYCLES-1), else RUN.
  - Else if load_use: pc_write=0, ifid_stall=1, idex_flush=1. Stay in RUN; this is exactly one bubble per hazard.
- FLUSH:
  - ifid_flush=1, if_valid=0.
  - branch_taken and load_use are ignored, since EX holds a bubble.
  - flush_cnt decrements each cycle; at 1, next state is RUN.
  - mem_busy in FLUSH: freeze as in RUN, flush_cnt holds, state stays FLUSH. wait_cnt counts and the timeout rules apply.
- MEM_WAIT:
  - While mem_busy: freeze outputs asserted, wait_cnt increments and saturates at 2^16-1.
  - When wait_cnt reaches MEM_TIMEOUT, mem_timeout sets. It stays set until reset.
  - When mem_busy=0: this cycle is evaluated with RUN rules (branch/load_use honoured), next state follows RUN, wait_cnt=0.
- Simultaneous branch_taken and load_use: redirect wins, no stall. The ID instruction is flushed anyway.
- ex_rd=0 never causes a stall.
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns immediately to RUN with counters cleared.

Optional Feature:
PIPE_HAZARD_CTRL_PERF_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both cleared by reset.
  - stall_cycles increments every cycle pc_write=0.
  - flush_events increments once per accepted redirect.
  - Both wrap at 2^32.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset check: reset=0 mid-operation -> state_o=0, mem_timeout=0, pc_write=1, all stall/flush outputs 0, all asynchronous (before the next clk edge).
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 for one cycle -> pc_write=0, ifid_stall=1, idex_flush=1 that cycle only. Repeat with ex_rd=0 -> no stall.
- Branch with FLUSH_CYCLES=3: branch_taken=1, ex_valid=1 -> cycle0 pc_redirect=1, ifid_flush=1, idex_flush=1; cycles1-2 ifid_flush=1, if_valid=0, state_o=1; cycle3 state_o=0.
- Branch+load_use same cycle -> pc_redirect=1, pc_write=1, no ifid_stall.
- mem_busy for 4 cycles with MEM_TIMEOUT=255 -> pc_write=0, ifid_stall=idex_stall=1 for 4 cycles, state_o=2, mem_timeout=0. Then branch_taken on the release cycle -> pc_redirect=1 that cycle.
- MEM_TIMEOUT=3: mem_busy held 5 cycles -> mem_timeout=1 from the 3rd busy cycle; remains 1 after mem_busy=0 until reset. With PIPE_HAZARD_CTRL_PERF_EN, stall_cycles=5.
